// File: rtl/dtim_pkg.sv
// dtim_pkg: shared dmem interface records, DTIM responder state and defaults
package dtim_pkg;
  localparam logic [31:0] DTIM_BASE = 32'h0001_0000;
  localparam int DTIM_DEPTH = 4096;
  typedef struct packed {
    logic valid;
    logic fence;
    logic instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0] wstrb;
  } mem_in_type;
  typedef struct packed {
    logic ready;
    logic [31:0] rdata;
    logic error;
  } mem_out_type;
  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} dtim_state_type;
  typedef struct packed {
    dtim_state_type state;
    logic [3:0] cnt;
    mem_in_type req;
    logic oor;
    mem_out_type rsp;
  } dtim_reg_type;
  function automatic logic [3:0] byte_parity(input logic [31:0] w);
    return {^w[31:24], ^w[23:16], ^w[15:8], ^w[7:0]};
  endfunction
endpackage

// File: rtl/dtim_ram.sv
// dtim_ram: single-port byte-write SRAM with synchronous read
// DTIM_PARITY_EN adds one even-parity bit per byte, checked on every read.
module dtim_ram import dtim_pkg::*; #(
  parameter int DEPTH = DTIM_DEPTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          en,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata,
  output logic          perr
);
  logic [31:0] mem [DEPTH];
`ifdef DTIM_PARITY_EN
  logic [3:0] par [DEPTH];
  logic [3:0] wpar;
  assign wpar = byte_parity(wdata);
  always_ff @(posedge clock)
    if (en) begin
      for (int i = 0; i < 4; i++)
        if (we[i]) begin
          mem[addr][8*i +: 8] <= wdata[8*i +: 8];
          par[addr][i] <= wpar[i];
        end
      rdata <= mem[addr];
      perr <= |(par[addr] ^ byte_parity(mem[addr]));
    end
`else
  assign perr = 1'b0;
  always_ff @(posedge clock)
    if (en) begin
      for (int i = 0; i < 4; i++)
        if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      rdata <= mem[addr];
    end
`endif
endmodule

// File: rtl/dtim_responder.sv
// dtim_responder: dmem responder for the DTIM with configurable wait states
module dtim_responder import dtim_pkg::*; #(
  parameter int DEPTH = DTIM_DEPTH,
  parameter int WAIT_CYCLES = 1,
  parameter logic [31:0] BASE_ADDR = DTIM_BASE
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic        mem_fence,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        mem_error
);
  localparam int AW = $clog2(DEPTH);
  dtim_reg_type r, rin;
  logic [31:0] off, ram_rdata;
  logic ram_en, ram_perr, rd;
  assign off = mem_addr - BASE_ADDR;
  assign ram_en = r.state == ACCESS && !r.req.fence && !r.oor;
  assign rd = !r.req.fence && !r.oor && r.req.wstrb == 4'b0;
  assign {mem_ready, mem_rdata, mem_error} = r.rsp;
  dtim_ram #(.DEPTH(DEPTH)) u_ram (
    .clock(clock),
    .en(ram_en),
    .we(r.req.wstrb),
    .addr(r.req.addr[AW+1:2]),
    .wdata(r.req.wdata),
    .rdata(ram_rdata),
    .perr(ram_perr)
  );
  always_comb begin
    rin = r;
    rin.rsp = '0;
    unique case (r.state)
      IDLE:
        if (mem_valid) begin
          // the offset wraps for addresses below the base, so one compare covers both ends
          rin.req = {mem_valid, mem_fence, mem_instr, off, mem_wdata, mem_wstrb};
          rin.oor = off >= 32'(4 * DEPTH);
          rin.cnt = 4'(WAIT_CYCLES);
          rin.state = WAIT_CYCLES > 0 ? WAIT : ACCESS;
        end
      WAIT: begin
        rin.cnt = r.cnt - 4'd1;
        rin.state = r.cnt == 4'd1 ? ACCESS : WAIT;
      end
      ACCESS: rin.state = RESP;
      RESP: begin
        rin.rsp = {1'b1, rd ? ram_rdata : 32'h0, r.oor | (rd & ram_perr)};
        rin.state = IDLE;
      end
    endcase
  end
  always_ff @(posedge clock)
    if (!reset) r <= '0;
    else r <= rin;
endmodule

// File: tb/tb_dtim_responder.sv
// tb_dtim_responder: scoreboard bench for dtim_responder (WAIT_CYCLES 1 and 0 instances)
module tb_dtim_responder;
  import dtim_pkg::*;
  logic clk = 0, reset = 0;
  logic valid [2], fence [2], instr [2], ready [2], error [2];
  logic [31:0] addr [2], wdata [2], rdata [2];
  logic [3:0] wstrb [2];
  logic [8:0] mask;
  int vectors = 0, miscompares = 0;
  typedef struct {logic [31:0] rdata; logic error;} exp_t;
  exp_t sb [$];
`ifdef DTIM_PARITY_EN
  localparam logic PAR_ERR = 1'b1;
`else
  localparam logic PAR_ERR = 1'b0;
`endif
  always #5 clk = ~clk;
  dtim_responder #(.WAIT_CYCLES(1)) u0 (
    .clock(clk), .reset(reset), .mem_valid(valid[0]), .mem_fence(fence[0]), .mem_instr(instr[0]),
    .mem_addr(addr[0]), .mem_wdata(wdata[0]), .mem_wstrb(wstrb[0]),
    .mem_ready(ready[0]), .mem_rdata(rdata[0]), .mem_error(error[0])
  );
  dtim_responder #(.WAIT_CYCLES(0)) u1 (
    .clock(clk), .reset(reset), .mem_valid(valid[1]), .mem_fence(fence[1]), .mem_instr(instr[1]),
    .mem_addr(addr[1]), .mem_wdata(wdata[1]), .mem_wstrb(wstrb[1]),
    .mem_ready(ready[1]), .mem_rdata(rdata[1]), .mem_error(error[1])
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask
  task automatic req(input int d, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st,
                     input logic f, input logic [31:0] er, input logic ee);
    int n = 0;
    exp_t e;
    sb.push_back('{er, ee});
    valid[d] = 1; fence[d] = f; addr[d] = a; wdata[d] = wd; wstrb[d] = st;
    do begin
      @(posedge clk); #1;
      n++;
      valid[d] = 0; addr[d] = $urandom; wdata[d] = $urandom; wstrb[d] = 4'hF;
    end while (!ready[d] && n < 40);
    e = sb.pop_front();
    chk("ready", 32'(ready[d]), 32'd1);
    chk("latency", n - 1, d == 0 ? 3 : 2);
    chk("rdata", rdata[d], e.rdata);
    chk("error", 32'(error[d]), 32'(e.error));
    fence[d] = 0;
  endtask
  task automatic reset_phase();
    reset = 0;
    for (int d = 0; d < 2; d++) begin
      valid[d] = 1; fence[d] = 0; addr[d] = 32'h0001_0020; wdata[d] = 32'h0; wstrb[d] = 4'hF;
    end
    repeat (3) begin
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) chk("rst_out", {ready[d], error[d], rdata[d] != 0}, 32'd0);
    end
    for (int d = 0; d < 2; d++) valid[d] = 0;
    reset = 1;
  endtask
  initial begin
    for (int d = 0; d < 2; d++) instr[d] = 0;
    reset_phase();
    req(0, 32'h0001_0010, 32'hDEADBEEF, 4'hF, 0, 32'h0, 0);
    @(posedge clk); #1;
    chk("ready_pulse", 32'(ready[0]), 32'd0);
    req(0, 32'h0001_0010, 32'h0, 4'h0, 0, 32'hDEADBEEF, 0);
    req(0, 32'h0001_0010, 32'h00AA0000, 4'b0100, 0, 32'h0, 0);
    req(0, 32'h0001_0010, 32'h0, 4'h0, 0, 32'hDEAABEEF, 0);
    req(0, 32'h0001_0010, 32'h11223344, 4'b0110, 0, 32'h0, 0);
    req(0, 32'h0001_0010, 32'h0, 4'h0, 0, 32'hDE2233EF, 0);
    req(0, 32'h0000_FFFC, 32'h0, 4'h0, 0, 32'h0, 1);
    req(0, 32'h0001_4000, 32'h0, 4'h0, 0, 32'h0, 1);
    req(0, 32'h0001_4010, 32'hFFFFFFFF, 4'hF, 0, 32'h0, 1);
    req(0, 32'h0001_0010, 32'hFFFFFFFF, 4'hF, 1, 32'h0, 0);
    req(0, 32'h0001_0010, 32'h0, 4'h0, 0, 32'hDE2233EF, 0);
    req(0, 32'h0001_3FFC, 32'h55AA55AA, 4'hF, 0, 32'h0, 0);
    req(0, 32'h0001_3FFC, 32'h0, 4'h0, 0, 32'h55AA55AA, 0);
    req(0, 32'h0001_0020, 32'hCAFEF00D, 4'hF, 0, 32'h0, 0);
    reset_phase();
    req(0, 32'h0001_0020, 32'h0, 4'h0, 0, 32'hCAFEF00D, 0);
    req(1, 32'h0001_0040, 32'hA5A5C3C3, 4'hF, 0, 32'h0, 0);
    req(1, 32'h0001_0040, 32'h0, 4'h0, 0, 32'hA5A5C3C3, 0);
    fence[1] = 1; wstrb[1] = 4'h0; addr[1] = 32'h0001_0040; valid[1] = 1; mask = '0;
    for (int n = 1; n <= 9; n++) begin
      @(posedge clk); #1;
      mask[n-1] = ready[1];
      if (ready[1]) chk("hold_resp", {rdata[1] != 0, error[1]}, 32'd0);
      if (n == 6) valid[1] = 0;
    end
    fence[1] = 0;
    chk("hold_mask", 32'(mask), 32'h024);
    req(0, 32'h0001_0030, 32'h12345678, 4'hF, 0, 32'h0, 0);
    u0.u_ram.mem[12] = u0.u_ram.mem[12] ^ 32'h8;
    req(0, 32'h0001_0030, 32'h0, 4'h0, 0, 32'h12345670, PAR_ERR);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
